// File: rtl/argmax_n.sv
`default_nettype none
// ============================================================================
// Module      : argmax_n
// Description : Sequential argmax over IN_NUM captured scores. One comparator
//               scans one element per cycle; the winner is reported as a
//               one-hot vector, a binary index and the winning score.
//               Upstream handshake is pre_finish/i_read, downstream is
//               finish/later_read.
// Revision    : 1.0 - initial release
// ============================================================================
module argmax_n #(
  parameter int IN_NUM      = 10,
  parameter int PIXEL_WIDTH = 18,
  parameter int IDX_WIDTH   = 4,
  parameter int SIGNED_CMP  = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            pre_finish,
  output logic                            i_read,
  output logic                            finish,
  input  logic                            later_read,
  input  logic [0:IN_NUM*PIXEL_WIDTH-1]   in_data,
  output logic [0:IN_NUM-1]               out_onehot,
  output logic [IDX_WIDTH-1:0]            out_idx,
  output logic [PIXEL_WIDTH-1:0]          out_max
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [IDX_WIDTH-1:0] C_LAST = IDX_WIDTH'(IN_NUM - 1);

  logic [1:0]             r_state;
  logic [1:0]             w_next_state;
  logic [PIXEL_WIDTH-1:0] r_arr [IN_NUM];
  logic [IDX_WIDTH-1:0]   r_cnt;
  logic [PIXEL_WIDTH-1:0] r_best;
  logic [IDX_WIDTH-1:0]   r_best_idx;

  logic                   w_capture;
  logic                   w_last;
  logic [PIXEL_WIDTH-1:0] w_cur;
  logic                   w_gt;
  logic                   w_take;
  logic [PIXEL_WIDTH-1:0] w_new_best;
  logic [IDX_WIDTH-1:0]   w_new_idx;
  logic [0:IN_NUM-1]      w_onehot;

  assign w_capture = (r_state == S_IDLE) && pre_finish;
  assign w_last    = (r_state == S_BUSY) && (r_cnt == C_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; unused encodings fall back to IDLE
  always_comb begin
    w_next_state = S_IDLE;
    case (r_state)
      S_IDLE: w_next_state = pre_finish ? S_BUSY : S_IDLE;
      S_BUSY: w_next_state = w_last ? S_DONE : S_BUSY;
      S_DONE: w_next_state = later_read ? S_IDLE : S_DONE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state; i_read marks the first scan cycle
  always_comb begin
    i_read = (r_state == S_BUSY) && (r_cnt == '0);
    finish = (r_state == S_DONE);
  end

  // Select the element addressed by the scan counter
  always_comb begin
    w_cur = '0;
    for (int i = 0; i < IN_NUM; i++) begin
      if (r_cnt == IDX_WIDTH'(i)) begin
        w_cur = r_arr[i];
      end
    end
  end

  // Single comparator: strictly greater keeps the lower index on ties
  always_comb begin
    if (SIGNED_CMP != 0) begin
      w_gt = $signed(w_cur) > $signed(r_best);
    end else begin
      w_gt = w_cur > r_best;
    end
    w_take     = (r_cnt == '0) || w_gt;
    w_new_best = w_take ? w_cur : r_best;
    w_new_idx  = w_take ? r_cnt : r_best_idx;
  end

  // One-hot decode of the running winner, registered on the last scan edge
  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < IN_NUM; i++) begin
      w_onehot[i] = (w_new_idx == IDX_WIDTH'(i));
    end
  end

  // Capture, scan and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IN_NUM; i++) begin
        r_arr[i] <= '0;
      end
      r_cnt      <= '0;
      r_best     <= '0;
      r_best_idx <= '0;
      out_onehot <= '0;
      out_idx    <= '0;
      out_max    <= '0;
    end else begin
      if (w_capture) begin
        for (int i = 0; i < IN_NUM; i++) begin
          r_arr[i] <= in_data[i*PIXEL_WIDTH +: PIXEL_WIDTH];
        end
        r_cnt <= '0;
      end else if (r_state == S_BUSY) begin
        r_best     <= w_new_best;
        r_best_idx <= w_new_idx;
        if (w_last) begin
          r_cnt      <= '0;
          out_onehot <= w_onehot;
          out_idx    <= w_new_idx;
          out_max    <= w_new_best;
        end else begin
          r_cnt <= r_cnt + IDX_WIDTH'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_argmax_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_argmax_n
// Description : Self-checking bench for argmax_n: a signed and an unsigned
//               N=10 instance fed the same vectors, plus an N=1 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_argmax_n;

  typedef logic [17:0] vec_t [10];
  typedef struct {
    logic [3:0]  idx;
    logic [17:0] mx;
    logic [0:9]  oh;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         pre, lr;
  logic [0:179] in_vec;
  logic         a_iread, a_fin, b_iread, b_fin;
  logic [0:9]   a_oh, b_oh;
  logic [3:0]   a_idx, b_idx;
  logic [17:0]  a_max, b_max;

  logic         c_pre, c_lr, c_iread, c_fin;
  logic [0:17]  c_in;
  logic [0:0]   c_oh;
  logic [0:0]   c_idx;
  logic [17:0]  c_max;

  int n_cmp = 0;
  int n_err = 0;
  exp_t sbA[$];
  exp_t sbB[$];

  argmax_n #(.IN_NUM(10), .PIXEL_WIDTH(18), .IDX_WIDTH(4), .SIGNED_CMP(1)) u_a (
    .clk(clk), .rst_n(rst_n), .pre_finish(pre), .i_read(a_iread), .finish(a_fin),
    .later_read(lr), .in_data(in_vec), .out_onehot(a_oh), .out_idx(a_idx), .out_max(a_max));

  argmax_n #(.IN_NUM(10), .PIXEL_WIDTH(18), .IDX_WIDTH(4), .SIGNED_CMP(0)) u_b (
    .clk(clk), .rst_n(rst_n), .pre_finish(pre), .i_read(b_iread), .finish(b_fin),
    .later_read(lr), .in_data(in_vec), .out_onehot(b_oh), .out_idx(b_idx), .out_max(b_max));

  argmax_n #(.IN_NUM(1), .PIXEL_WIDTH(18), .IDX_WIDTH(1), .SIGNED_CMP(1)) u_c (
    .clk(clk), .rst_n(rst_n), .pre_finish(c_pre), .i_read(c_iread), .finish(c_fin),
    .later_read(c_lr), .in_data(c_in), .out_onehot(c_oh), .out_idx(c_idx), .out_max(c_max));

  function automatic exp_t model(input vec_t s, input bit sgn);
    exp_t e;
    logic [17:0] best;
    int bi;
    bit gt;
    best = s[0];
    bi = 0;
    for (int k = 1; k < 10; k++) begin
      gt = sgn ? ($signed(s[k]) > $signed(best)) : (s[k] > best);
      if (gt) begin
        best = s[k];
        bi = k;
      end
    end
    e.idx = 4'(bi);
    e.mx  = best;
    e.oh  = '0;
    e.oh[bi] = 1'b1;
    return e;
  endfunction

  function automatic logic [0:179] pack(input vec_t s);
    logic [0:179] p;
    for (int k = 0; k < 10; k++) p[k*18 +: 18] = s[k];
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input vec_t s);
    sbA.push_back(model(s, 1'b1));
    sbB.push_back(model(s, 1'b0));
  endtask

  // Capture a vector and wait (bounded) for finish; optionally pokes pre_finish mid-scan
  task automatic run_vector(input vec_t s, input bit poke, output int lat, output int irc);
    in_vec = pack(s);
    pre = 1'b1;
    tick();
    pre = 1'b0;
    irc = (a_iread === 1'b1) ? 1 : 0;
    lat = 0;
    while (a_fin !== 1'b1 && lat < 40) begin
      pre = poke && (lat == 2);
      if (poke && lat == 2) in_vec = '1;
      tick();
      lat++;
      if (a_iread === 1'b1) irc++;
    end
    pre = 1'b0;
  endtask

  task automatic release_out();
    tick();
    lr = 1'b1;
    tick();
    lr = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (a_iread !== 1'b0 || a_fin !== 1'b0) begin n_err++;
      $display("FAIL reset_hs: i_read=%b finish=%b expected 0 0", a_iread, a_fin); end
    n_cmp++; if (a_oh !== 10'b0 || a_idx !== 4'd0 || a_max !== 18'd0) begin n_err++;
      $display("FAIL reset_out: oh=%b idx=%0d max=%h expected zeros", a_oh, a_idx, a_max); end
    n_cmp++; if (b_fin !== 1'b0 || c_fin !== 1'b0 || c_max !== 18'd0) begin n_err++;
      $display("FAIL reset_bc: b_fin=%b c_fin=%b c_max=%h expected 0 0 0", b_fin, c_fin, c_max); end
  endtask

  task automatic test_ascending();
    vec_t s; int lat, irc; exp_t ea, eb;
    for (int k = 0; k < 10; k++) s[k] = 18'(k);
    push_exp(s);
    run_vector(s, 1'b0, lat, irc);
    n_cmp++; if (lat !== 10) begin n_err++; $display("FAIL asc_latency: got %0d expected 10", lat); end
    n_cmp++; if (irc !== 1) begin n_err++; $display("FAIL asc_iread_pulses: got %0d expected 1", irc); end
    ea = sbA.pop_front(); eb = sbB.pop_front();
    n_cmp++; if (a_idx !== ea.idx || a_oh !== ea.oh || a_max !== ea.mx) begin n_err++;
      $display("FAIL asc_a: idx=%0d oh=%b max=%h expected %0d %b %h", a_idx, a_oh, a_max, ea.idx, ea.oh, ea.mx); end
    n_cmp++; if (b_fin !== 1'b1 || b_idx !== eb.idx || b_oh !== eb.oh || b_max !== eb.mx) begin n_err++;
      $display("FAIL asc_b: fin=%b idx=%0d oh=%b max=%h expected 1 %0d %b %h", b_fin, b_idx, b_oh, b_max, eb.idx, eb.oh, eb.mx); end
    release_out();
    n_cmp++; if (a_fin !== 1'b0) begin n_err++; $display("FAIL asc_release: finish=%b expected 0", a_fin); end
    n_cmp++; if (a_idx !== ea.idx || a_max !== ea.mx) begin n_err++;
      $display("FAIL asc_held_after_release: idx=%0d max=%h expected %0d %h", a_idx, a_max, ea.idx, ea.mx); end
  endtask

  task automatic test_ties();
    vec_t s; int lat, irc; exp_t ea, eb;
    for (int k = 0; k < 10; k++) s[k] = 18'd5;
    s[3] = 18'd100; s[7] = 18'd100;
    push_exp(s);
    run_vector(s, 1'b0, lat, irc);
    ea = sbA.pop_front(); eb = sbB.pop_front();
    n_cmp++; if (lat !== 10 || a_idx !== ea.idx || a_oh !== ea.oh || a_max !== ea.mx) begin n_err++;
      $display("FAIL ties_a: lat=%0d idx=%0d oh=%b max=%h expected 10 %0d %b %h", lat, a_idx, a_oh, a_max, ea.idx, ea.oh, ea.mx); end
    n_cmp++; if (b_idx !== eb.idx || b_oh !== eb.oh || b_max !== eb.mx) begin n_err++;
      $display("FAIL ties_b: idx=%0d oh=%b max=%h expected %0d %b %h", b_idx, b_oh, b_max, eb.idx, eb.oh, eb.mx); end
    release_out();
  endtask

  task automatic test_signed_unsigned();
    vec_t s; int lat, irc; exp_t ea, eb;
    int neg [10] = '{-5, -3, -8, -1, -20, -2, -9, -7, -4, -6};
    for (int k = 0; k < 10; k++) s[k] = 18'(neg[k]);
    push_exp(s);
    run_vector(s, 1'b0, lat, irc);
    ea = sbA.pop_front(); eb = sbB.pop_front();
    n_cmp++; if (a_idx !== ea.idx || a_oh !== ea.oh || a_max !== ea.mx) begin n_err++;
      $display("FAIL neg_signed: idx=%0d oh=%b max=%h expected %0d %b %h", a_idx, a_oh, a_max, ea.idx, ea.oh, ea.mx); end
    n_cmp++; if (b_idx !== eb.idx || b_max !== eb.mx) begin n_err++;
      $display("FAIL neg_unsigned: idx=%0d max=%h expected %0d %h", b_idx, b_max, eb.idx, eb.mx); end
    release_out();
    for (int k = 0; k < 10; k++) s[k] = 18'd0;
    s[0] = 18'd1; s[1] = 18'h3FFFF;
    push_exp(s);
    run_vector(s, 1'b0, lat, irc);
    ea = sbA.pop_front(); eb = sbB.pop_front();
    n_cmp++; if (a_idx !== ea.idx || a_oh !== ea.oh || a_max !== ea.mx) begin n_err++;
      $display("FAIL mix_signed: idx=%0d oh=%b max=%h expected %0d %b %h", a_idx, a_oh, a_max, ea.idx, ea.oh, ea.mx); end
    n_cmp++; if (b_idx !== eb.idx || b_oh !== eb.oh || b_max !== eb.mx) begin n_err++;
      $display("FAIL mix_unsigned: idx=%0d oh=%b max=%h expected %0d %b %h", b_idx, b_oh, b_max, eb.idx, eb.oh, eb.mx); end
    release_out();
  endtask

  task automatic test_handshake();
    vec_t s; int lat, irc; exp_t ea, eb;
    for (int k = 0; k < 10; k++) s[k] = 18'(k * 3);
    s[6] = 18'd777;
    push_exp(s);
    run_vector(s, 1'b1, lat, irc);
    ea = sbA.pop_front(); eb = sbB.pop_front();
    n_cmp++; if (lat !== 10 || irc !== 1 || a_idx !== ea.idx || a_max !== ea.mx || a_oh !== ea.oh) begin n_err++;
      $display("FAIL hs_busy_poke: lat=%0d irc=%0d idx=%0d max=%h expected 10 1 %0d %h", lat, irc, a_idx, a_max, ea.idx, ea.mx); end
    for (int c = 0; c < 20; c++) begin
      pre = (c == 5);
      if (c == 5) in_vec = '1;
      tick();
      n_cmp++; if (a_fin !== 1'b1 || a_iread !== 1'b0 || a_idx !== ea.idx || a_max !== ea.mx || a_oh !== ea.oh) begin n_err++;
        $display("FAIL hs_hold_c%0d: fin=%b iread=%b idx=%0d max=%h expected 1 0 %0d %h", c, a_fin, a_iread, a_idx, a_max, ea.idx, ea.mx); end
    end
    pre = 1'b0;
    lr = 1'b1;
    tick();
    lr = 1'b0;
    n_cmp++; if (a_fin !== 1'b0) begin n_err++; $display("FAIL hs_release: finish=%b expected 0", a_fin); end
    tick();
    n_cmp++; if (a_iread !== 1'b0) begin n_err++; $display("FAIL hs_no_recapture: i_read=%b expected 0", a_iread); end
    s[0] = 18'd900;
    push_exp(s);
    run_vector(s, 1'b0, lat, irc);
    ea = sbA.pop_front(); eb = sbB.pop_front();
    n_cmp++; if (a_idx !== ea.idx || a_oh !== ea.oh || a_max !== ea.mx) begin n_err++;
      $display("FAIL hs_second_idx0: idx=%0d oh=%b max=%h expected %0d %b %h", a_idx, a_oh, a_max, ea.idx, ea.oh, ea.mx); end
  endtask

  // Enters in DONE; pre_finish and later_read together must only release
  task automatic test_back_to_back();
    vec_t s; int lat, irc; exp_t ea, eb;
    for (int k = 0; k < 10; k++) s[k] = 18'(20 - k);
    s[8] = 18'd4000;
    push_exp(s);
    in_vec = pack(s);
    pre = 1'b1;
    lr = 1'b1;
    tick();
    lr = 1'b0;
    n_cmp++; if (a_fin !== 1'b0 || a_iread !== 1'b0) begin n_err++;
      $display("FAIL b2b_release_only: fin=%b iread=%b expected 0 0", a_fin, a_iread); end
    run_vector(s, 1'b0, lat, irc);
    ea = sbA.pop_front(); eb = sbB.pop_front();
    n_cmp++; if (lat !== 10 || irc !== 1) begin n_err++;
      $display("FAIL b2b_latency: lat=%0d irc=%0d expected 10 1", lat, irc); end
    n_cmp++; if (a_idx !== ea.idx || a_oh !== ea.oh || a_max !== ea.mx) begin n_err++;
      $display("FAIL b2b_result: idx=%0d oh=%b max=%h expected %0d %b %h", a_idx, a_oh, a_max, ea.idx, ea.oh, ea.mx); end
  endtask

  task automatic test_reset_mid();
    vec_t s; int lat, irc; exp_t ea, eb;
    release_out();
    for (int k = 0; k < 10; k++) s[k] = 18'(k + 1);
    s[2] = 18'd3000;
    in_vec = pack(s);
    pre = 1'b1;
    tick();
    pre = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (a_fin !== 1'b0 || a_iread !== 1'b0) begin n_err++;
      $display("FAIL rst_mid_hs: fin=%b iread=%b expected 0 0", a_fin, a_iread); end
    n_cmp++; if (a_oh !== 10'b0 || a_idx !== 4'd0 || a_max !== 18'd0) begin n_err++;
      $display("FAIL rst_mid_out: oh=%b idx=%0d max=%h expected zeros", a_oh, a_idx, a_max); end
    repeat (2) tick();
    rst_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      tick();
      n_cmp++; if (a_fin !== 1'b0) begin n_err++; $display("FAIL rst_mid_no_finish_c%0d: fin=%b expected 0", c, a_fin); end
    end
    push_exp(s);
    run_vector(s, 1'b0, lat, irc);
    ea = sbA.pop_front(); eb = sbB.pop_front();
    n_cmp++; if (lat !== 10 || a_idx !== ea.idx || a_oh !== ea.oh || a_max !== ea.mx) begin n_err++;
      $display("FAIL rst_mid_rerun: lat=%0d idx=%0d max=%h expected 10 %0d %h", lat, a_idx, a_max, ea.idx, ea.mx); end
    release_out();
  endtask

  task automatic test_n1();
    c_in = 18'h3FFF9;
    c_pre = 1'b1;
    tick();
    c_pre = 1'b0;
    n_cmp++; if (c_iread !== 1'b1 || c_fin !== 1'b0) begin n_err++;
      $display("FAIL n1_t0p1: iread=%b fin=%b expected 1 0", c_iread, c_fin); end
    tick();
    n_cmp++; if (c_fin !== 1'b1 || c_iread !== 1'b0) begin n_err++;
      $display("FAIL n1_finish: fin=%b iread=%b expected 1 0", c_fin, c_iread); end
    n_cmp++; if (c_idx !== 1'b0 || c_oh !== 1'b1 || c_max !== 18'h3FFF9) begin n_err++;
      $display("FAIL n1_result: idx=%0d oh=%b max=%h expected 0 1 3fff9", c_idx, c_oh, c_max); end
    c_lr = 1'b1;
    tick();
    c_lr = 1'b0;
    n_cmp++; if (c_fin !== 1'b0) begin n_err++; $display("FAIL n1_release: fin=%b expected 0", c_fin); end
  endtask

  initial begin
    rst_n = 1'b0; pre = 1'b0; lr = 1'b0; in_vec = '0;
    c_pre = 1'b0; c_lr = 1'b0; c_in = '0;
    repeat (2) tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_ascending();
    test_ties();
    test_signed_unsigned();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    test_n1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
